// File: rtl/keen_decode_pkg.sv
// Shared opcode constants, immediate-format codes and decoded payload type
// for the keen decode stage.
package keen_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        fmt_e        fmt;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/keen_imm_select.sv
// Combinational RV32I format classifier and sign-extended immediate builder.
// Unknown opcodes report illegal with format R and a zero immediate.
module keen_imm_select
    import keen_decode_pkg::*;
(
    input  logic [31:0] insn,
    output fmt_e        fmt,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [6:0] w_op;

    assign w_op = insn[6:0];

    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        unique case (1'b1)
            (insn[1:0] != 2'b11):                   illegal = 1'b1;
            (w_op == OP_LUI) || (w_op == OP_AUIPC): fmt = FMT_U;
            (w_op == OP_JAL):                       fmt = FMT_J;
            (w_op == OP_JALR) || (w_op == OP_LOAD) ||
            (w_op == OP_IMM) || (w_op == OP_SYSTEM) ||
            (w_op == OP_FENCE):                     fmt = FMT_I;
            (w_op == OP_STORE):                     fmt = FMT_S;
            (w_op == OP_BRANCH):                    fmt = FMT_B;
            (w_op == OP_REG):                       fmt = FMT_R;
            default:                                illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{20{insn[31]}}, insn[31:20]};
            FMT_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            FMT_B: imm = {{19{insn[31]}}, insn[31], insn[7],
                          insn[30:25], insn[11:8], 1'b0};
            FMT_U: imm = {insn[31:12], 12'b0};
            FMT_J: imm = {{11{insn[31]}}, insn[31], insn[19:12],
                          insn[20], insn[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/keen_decode_stage.sv
// RV32I decode pipeline stage with valid/ready handshakes on both sides.
// Define KEEN_DECODE_SKID_EN for a skid entry and a registered in_ready.
module keen_decode_stage
    import keen_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    fmt_e        w_fmt;
    logic [31:0] w_imm;
    logic        w_illegal;
    dec_t        w_dec;
    dec_t        r_out;
    logic        r_out_valid;

    keen_imm_select u_imm (
        .insn    (in_insn),
        .fmt     (w_fmt),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.opcode  = in_insn[6:0];
        w_dec.funct3  = in_insn[14:12];
        w_dec.funct7  = in_insn[31:25];
        w_dec.rd      = in_insn[11:7];
        w_dec.rs1     = in_insn[19:15];
        w_dec.rs2     = in_insn[24:20];
        w_dec.fmt     = w_fmt;
        w_dec.imm     = w_imm;
        w_dec.illegal = w_illegal;
    end

`ifdef KEEN_DECODE_SKID_EN
    dec_t r_skid;
    logic r_skid_valid;
    logic w_acc;

    // in_ready comes straight from a flop, so out_ready never reaches it
    assign in_ready = !r_skid_valid;
    assign w_acc    = in_valid && !r_skid_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_acc;
                if (w_acc)
                    r_out <= w_dec;
            end
        end else if (w_acc) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (in_ready) begin
            r_out_valid <= in_valid;
            if (in_valid)
                r_out <= w_dec;
        end
    end
`endif

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out.pc;
    assign out_opcode  = r_out.opcode;
    assign out_funct3  = r_out.funct3;
    assign out_funct7  = r_out.funct7;
    assign out_rd      = r_out.rd;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_fmt     = r_out.fmt;
    assign out_imm     = r_out.imm;
    assign out_illegal = r_out.illegal;

endmodule

// File: tb/tb_keen_decode_stage.sv
// Directed-vector bench for keen_decode_stage.
module tb_keen_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_insn = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_fmt;
    logic [31:0] out_imm;
    logic        out_illegal;

    int n_vec = 0;
    int n_bad = 0;

    keen_decode_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_insn     (in_insn),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_fmt     (out_fmt),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-word decode: present, take one edge, check the registered result.
    task automatic dec1(input string tag, input logic [31:0] insn,
                        input logic [31:0] pc, input logic [2:0] fmt,
                        input logic [31:0] imm, input logic ill,
                        input logic [4:0] rd);
        in_valid  = 1'b1;
        in_insn   = insn;
        in_pc     = pc;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".pc"},    out_pc, pc);
        chk({tag, ".fmt"},   {29'b0, out_fmt}, {29'b0, fmt});
        chk({tag, ".imm"},   out_imm, imm);
        chk({tag, ".ill"},   {31'b0, out_illegal}, {31'b0, ill});
        chk({tag, ".rd"},    {27'b0, out_rd}, {27'b0, rd});
        chk({tag, ".op"},    {25'b0, out_opcode}, {25'b0, insn[6:0]});
    endtask

    logic [31:0] words [4];
    logic [31:0] got_pc [$];
    logic [31:0] held_pc;
    logic        held;
    int          sent;
    logic        acc, drn;

    initial begin
        #2;
        chk("rst.valid", {31'b0, out_valid}, 32'd0);
        chk("rst.imm",   out_imm, 32'd0);
        chk("rst.fmt",   {29'b0, out_fmt}, 32'd0);
        chk("rst.ill",   {31'b0, out_illegal}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);

        dec1("addi", 32'hFFF00093, 32'h100, 3'd1, 32'hFFFFFFFF, 1'b0, 5'd1);
        dec1("sw",   32'hFE20AE23, 32'h104, 3'd2, 32'hFFFFFFFC, 1'b0, 5'd28);
        chk("sw.rs1", {27'b0, out_rs1}, 32'd1);
        chk("sw.rs2", {27'b0, out_rs2}, 32'd2);
        chk("sw.f3",  {29'b0, out_funct3}, 32'd2);
        chk("sw.f7",  {25'b0, out_funct7}, 32'h7F);
        dec1("lui",  32'h123452B7, 32'h108, 3'd4, 32'h12345000, 1'b0, 5'd5);
        dec1("ill",  32'h0000007F, 32'h10C, 3'd0, 32'h0, 1'b1, 5'd0);
        dec1("beq",  32'hFE000EE3, 32'h110, 3'd3, 32'hFFFFFFFC, 1'b0, 5'd29);
        dec1("jal",  32'h008000EF, 32'h114, 3'd5, 32'h8, 1'b0, 5'd1);
        dec1("add",  32'h002081B3, 32'h118, 3'd0, 32'h0, 1'b0, 5'd3);
        dec1("lowb", 32'h00000010, 32'h11C, 3'd0, 32'h0, 1'b1, 5'd0);
        step();
        chk("idle.valid", {31'b0, out_valid}, 32'd0);

        // Stream 4 words while the sink stalls for the first 3 cycles.
        for (int i = 0; i < 4; i++)
            words[i] = 32'h200 + 32'(i * 4);
        sent = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (sent < 4);
            in_pc     = (sent < 4) ? words[sent] : 32'h0;
            in_insn   = 32'h00000013;
            #1;
            if (held && out_valid)
                chk("stall.stable", out_pc, held_pc);
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (drn)
                got_pc.push_back(out_pc);
            held    = out_valid && !out_ready;
            held_pc = out_pc;
            @(posedge clk);
            if (acc)
                sent++;
            #1;
`ifdef KEEN_DECODE_SKID_EN
            if (acc && sent == 2 && !out_ready)
                chk("skid.in_ready", {31'b0, in_ready}, 32'd0);
`endif
        end
        in_valid = 1'b0;
        chk("stream.count", 32'(got_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_pc.size())
                chk("stream.order", got_pc[i], words[i]);

        // Flush with a held word and a word offered simultaneously.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h300;
        step();
        in_pc = 32'h304;
        step();
        chk("fl.pre", {31'b0, out_valid}, 32'd1);
        flush = 1'b1;
        in_pc = 32'h308;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl.valid", {31'b0, out_valid}, 32'd0);
        chk("fl.in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl.drop", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = 32'hFFF00093;
        in_pc     = 32'h400;
        step();
        in_valid = 1'b0;
        chk("ar.pre", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.valid", {31'b0, out_valid}, 32'd0);
        chk("ar.pc",    out_pc, 32'd0);
        chk("ar.imm",   out_imm, 32'd0);
        chk("ar.fmt",   {29'b0, out_fmt}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("ar.in_ready", {31'b0, in_ready}, 32'd1);
        chk("ar.post", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/keen_decode_stage.md
KEEN_DECODE_STAGE -- requirements
Module: keen_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and immediate output width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 flush  input  1  synchronous squash of all held instructions.
REQ-005 in_valid  input  1  upstream fetch word valid.
REQ-006 in_ready  output  1  stage can accept a word this cycle.
REQ-007 in_insn  input  32  raw RV32I instruction word.
REQ-008 in_pc  input  XLEN  PC of in_insn.
REQ-009 out_valid  output  1  decoded instruction valid.
REQ-010 out_ready  input  1  downstream accepts the decoded instruction.
REQ-011 out_pc  output  XLEN  PC passed through.
REQ-012 out_opcode / out_funct3 / out_funct7  output  7/3/7  insn[6:0], insn[14:12], insn[31:25].
REQ-013 out_rd / out_rs1 / out_rs2  output  5/5/5  insn[11:7], insn[19:15], insn[24:20].
REQ-014 out_fmt  output  3  immediate format code: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-015 out_imm  output  XLEN  fully sign-extended immediate.
REQ-016 out_illegal  output  1  opcode outside the supported set.

Function
REQ-017 A transfer occurs on each side when valid and ready are both high at a rising edge; payload is held stable while out_valid is high and out_ready is low.
REQ-018 Decode is combinational on in_insn; results are registered; latency in_valid -> out_valid is exactly 1 cycle.
REQ-019 Format map: 0110111/0010111 -> U; 1101111 -> J; 1100111, 0000011, 0010011, 1110011, 0001111 -> I; 0100011 -> S; 1100011 -> B; 0110011 -> R.
REQ-020 Immediates: I = sext(insn[31:20]); S = sext({insn[31:25],insn[11:7]}); B = sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0}); U = {insn[31:12],12'b0}; J = sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0}); R -> 0.
REQ-021 Any other opcode, or insn[1:0] != 2'b11, sets out_illegal=1, out_fmt=R, out_imm=0; the instruction still flows.
REQ-022 Without skid: in_ready = !out_valid || out_ready (single register, full throughput).
REQ-023 flush clears every valid bit at the next edge, overrides a simultaneous input transfer, and the squashed word is dropped.
REQ-024 Simultaneous accept and drain in one cycle keep out_valid high with the new payload.

Reset
REQ-025 rst asserted: out_valid=0, skid valid=0, all payload outputs 0 (out_fmt=0, out_illegal=0), in_ready=1 from the first cycle after deassertion.
REQ-026 Reset mid-operation discards any held instruction; no partial transfer completes.

Configuration
REQ-027 Macro KEEN_DECODE_SKID_EN defined: a one-entry skid register is added; in_ready is registered and equals !skid_valid; a word arriving while out is stalled goes to skid and moves to out when out_ready rises; throughput 1/cycle, no combinational out_ready -> in_ready path.
REQ-028 Macro undefined: behaviour per REQ-022; no skid storage exists.

Structure
REQ-029 Package keen_decode_pkg holds opcode constants, the fmt enumeration/constants and the decoded-payload struct.
REQ-030 Sub-module keen_imm_select: combinational, inputs insn[31:0], outputs fmt, imm, illegal; the stage instantiates it once per payload input.

Verification
REQ-031 in_insn=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, fmt=I, rd=1, imm=0xFFFFFFFF.
REQ-032 in_insn=0xFE20AE23 (sw x2,-4(x1)) -> fmt=S, rs1=1, rs2=2, imm=0xFFFFFFFC; 0x123452B7 (lui x5) -> fmt=U, rd=5, imm=0x12345000.
REQ-033 in_insn=0x0000007F -> out_illegal=1, fmt=0, imm=0, out_valid=1.
REQ-034 Stream 4 words with out_ready=0 for 3 cycles: out payload stable, no word lost or duplicated, order preserved; with KEEN_DECODE_SKID_EN, in_ready drops one cycle after the second word enters.
REQ-035 flush asserted with in_valid=1 and out_valid=1 -> next cycle out_valid=0, skid empty, in_ready=1.
REQ-036 rst pulsed asynchronously mid-stall -> out_valid=0 immediately, payload outputs 0.
